accelerator_core: RTL and testbench

ACCELERATOR_CORE -- requirements
Module: accelerator_core

---
 rtl/accelerator_core.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_accelerator_core.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/accelerator_core.sv
// ----------------------------------------------------------------------------
// accelerator_core
//
// Small multiply-accumulate engine. A job is started from IDLE by
// i_conf_ctrl[0]. The core fetches a weight word, then data words one at a
// time through a request/valid handshake. It refetches weights every
// "weightinterval" data words, and stops after "cnt" data words. For every
// accepted data word, each kernel produces the dot product of the data
// channels with that kernel's weights. The result is saturated to BIT_WIDTH.
//
// Ports
//   clk                    : clock, all logic on the rising edge
//   rst                    : synchronous reset, active low
//   o_weight_req           : one-cycle pulse asking for one weight word
//   i_weight, i_weight_val : weight word and its strobe (used only in WWAIT)
//   o_data_req             : one-cycle pulse asking for one data word
//   i_data, i_data_val     : data word and its strobe (used only in DWAIT)
//   o_psum_knK, _val       : per-kernel saturated result and one-cycle strobe
//   i_conf_ctrl            : bit0 start/enable
//   i_conf_cnt             : data words per job
//   i_conf_knx             : bits[3:0] per-kernel output enable
//   i_conf_weightinterval  : data words per weight set (0 = never reload)
//   i_conf_kernelshape     : bits[11:8] active channel count
// ----------------------------------------------------------------------------
module accelerator_core #(
    parameter int BIT_WIDTH   = 8,
    parameter int NUM_CHANNEL = 3,
    parameter int NUM_KERNEL  = 4,
    parameter int NUM_KCPE    = 3,
    parameter int REG_WIDTH   = 32
) (
    input  logic                                       clk,
    input  logic                                       rst,
    output logic                                       o_data_req,
    input  logic [BIT_WIDTH*NUM_CHANNEL-1:0]           i_data,
    input  logic                                       i_data_val,
    output logic                                       o_weight_req,
    input  logic [BIT_WIDTH*NUM_CHANNEL*NUM_KERNEL-1:0] i_weight,
    input  logic                                       i_weight_val,
    output logic [BIT_WIDTH-1:0]                       o_psum_kn0,
    output logic [BIT_WIDTH-1:0]                       o_psum_kn1,
    output logic [BIT_WIDTH-1:0]                       o_psum_kn2,
    output logic [BIT_WIDTH-1:0]                       o_psum_kn3,
    output logic                                       o_psum_kn0_val,
    output logic                                       o_psum_kn1_val,
    output logic                                       o_psum_kn2_val,
    output logic                                       o_psum_kn3_val,
    input  logic [REG_WIDTH-1:0]                       i_conf_ctrl,
    input  logic [REG_WIDTH-1:0]                       i_conf_cnt,
    input  logic [REG_WIDTH-1:0]                       i_conf_knx,
    input  logic [REG_WIDTH-1:0]                       i_conf_weightinterval,
    input  logic [REG_WIDTH-1:0]                       i_conf_kernelshape
);

    localparam int PROD_W = 2 * BIT_WIDTH;
    localparam int SUM_W  = PROD_W + $clog2(NUM_KCPE + 1);
    localparam int DATA_W = BIT_WIDTH * NUM_CHANNEL;
    localparam int WGT_W  = BIT_WIDTH * NUM_CHANNEL * NUM_KERNEL;
    localparam logic [3:0]           KCPE_N  = 4'(NUM_KCPE);
    localparam logic [SUM_W-1:0]     SAT_MAX = SUM_W'({BIT_WIDTH{1'b1}});
    localparam logic [REG_WIDTH-1:0] ONE     = REG_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WREQ  = 3'd1,
        WWAIT = 3'd2,
        DREQ  = 3'd3,
        DWAIT = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t state_q, state_d;

    // Job configuration, captured once at start and held for the whole job
    logic [REG_WIDTH-1:0]  cnt_q;
    logic [REG_WIDTH-1:0]  intv_q;
    logic [NUM_KERNEL-1:0] knx_q;
    logic [NUM_KCPE-1:0]   ch_en_q;

    // Progress counters
    logic [REG_WIDTH-1:0]  total_q, total_d;
    logic [REG_WIDTH-1:0]  icnt_q, icnt_d;
    logic [REG_WIDTH-1:0]  total_inc, icnt_inc;

    // Datapath registers
    logic [WGT_W-1:0]      weight_q;
    logic [DATA_W-1:0]     data_q;
    logic                  acc_q;
    logic [NUM_KERNEL-1:0][BIT_WIDTH-1:0] psum_q;
    logic [NUM_KERNEL-1:0]                val_q;
    logic [NUM_KERNEL-1:0][BIT_WIDTH-1:0] sat_val;

    // FSM decode strobes
    logic start;
    logic wload;
    logic accept;

    // Channel-enable mask decoded from the kernelshape field at start time
    logic [3:0]          shape_ch;
    logic                shape_full;
    logic [NUM_KCPE-1:0] ch_en_start;

    // Config bits that carry no function; folded into one sink
    logic unused_conf;
    assign unused_conf = ^{i_conf_ctrl[REG_WIDTH-1:1],
                           i_conf_knx[REG_WIDTH-1:NUM_KERNEL],
                           i_conf_kernelshape[REG_WIDTH-1:12],
                           i_conf_kernelshape[7:0]};

    assign shape_ch   = i_conf_kernelshape[11:8];
    // 0 or anything above the PE count means "use every channel"
    assign shape_full = (shape_ch == 4'd0) || (shape_ch > KCPE_N);

    genvar gi, gc;
    generate
        for (gi = 0; gi < NUM_KCPE; gi++) begin : g_ch_en
            assign ch_en_start[gi] = shape_full || (4'(gi) < shape_ch);
        end
    endgenerate

    assign total_inc = total_q + ONE;
    assign icnt_inc  = icnt_q + ONE;

    // ------------------------------------------------------------------
    // FSM: next state, counters and request outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        total_d      = total_q;
        icnt_d       = icnt_q;
        start        = 1'b0;
        wload        = 1'b0;
        accept       = 1'b0;
        o_weight_req = 1'b0;
        o_data_req   = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_conf_ctrl[0]) begin
                    start   = 1'b1;
                    total_d = '0;
                    icnt_d  = '0;
                    state_d = (i_conf_cnt == '0) ? DONE : WREQ;
                end
            end
            WREQ: begin
                o_weight_req = 1'b1;
                state_d      = WWAIT;
            end
            WWAIT: begin
                if (i_weight_val) begin
                    wload   = 1'b1;
                    state_d = DREQ;
                end
            end
            DREQ: begin
                o_data_req = 1'b1;
                state_d    = DWAIT;
            end
            DWAIT: begin
                if (i_data_val) begin
                    accept  = 1'b1;
                    total_d = total_inc;
                    icnt_d  = icnt_inc;
                    // Job completion wins over a weight reload due on the
                    // same word.
                    if (total_inc == cnt_q) begin
                        state_d = DONE;
                    end else if ((intv_q != '0) && (icnt_inc == intv_q)) begin
                        icnt_d  = '0;
                        state_d = WREQ;
                    end else begin
                        state_d = DREQ;
                    end
                end
            end
            DONE: begin
                if (!i_conf_ctrl[0]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            total_q <= '0;
            icnt_q  <= '0;
            cnt_q   <= '0;
            intv_q  <= '0;
            knx_q   <= '0;
            ch_en_q <= '0;
            acc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            total_q <= total_d;
            icnt_q  <= icnt_d;
            acc_q   <= accept;
            if (start) begin
                cnt_q   <= i_conf_cnt;
                intv_q  <= i_conf_weightinterval;
                knx_q   <= i_conf_knx[NUM_KERNEL-1:0];
                ch_en_q <= ch_en_start;
            end
        end
    end

    // ------------------------------------------------------------------
    // Operand registers. The data word is captured on the accepting edge,
    // and the result is registered one edge later. A weight reload can
    // land no earlier than two edges after an accept, so weight_q still
    // holds the set that belongs to the word in flight.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            weight_q <= '0;
            data_q   <= '0;
        end else begin
            if (wload) begin
                weight_q <= i_weight;
            end
            if (accept) begin
                data_q <= i_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Kernel x channel processing elements
    // ------------------------------------------------------------------
    generate
        for (gi = 0; gi < NUM_KERNEL; gi++) begin : g_kernel
            logic [NUM_KCPE-1:0][PROD_W-1:0] prod;
            logic [SUM_W-1:0]                sum;

            for (gc = 0; gc < NUM_KCPE; gc++) begin : g_pe
                logic [BIT_WIDTH-1:0] d_ch;
                logic [BIT_WIDTH-1:0] w_ch;
                assign d_ch = data_q[gc*BIT_WIDTH +: BIT_WIDTH];
                assign w_ch = weight_q[(gi*NUM_KCPE + gc)*BIT_WIDTH +: BIT_WIDTH];
                assign prod[gc] = ch_en_q[gc] ? (PROD_W'(d_ch) * PROD_W'(w_ch)) : '0;
            end

            always_comb begin
                sum = '0;
                for (int c = 0; c < NUM_KCPE; c++) begin
                    sum = sum + SUM_W'(prod[c]);
                end
            end

            assign sat_val[gi] = (sum > SAT_MAX) ? {BIT_WIDTH{1'b1}} : sum[BIT_WIDTH-1:0];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Result registers. A disabled kernel keeps its previous value and
    // never strobes.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            psum_q <= '0;
            val_q  <= '0;
        end else begin
            val_q <= acc_q ? knx_q : '0;
            for (int k = 0; k < NUM_KERNEL; k++) begin
                if (acc_q && knx_q[k]) begin
                    psum_q[k] <= sat_val[k];
                end
            end
        end
    end

    assign o_psum_kn0     = psum_q[0];
    assign o_psum_kn1     = psum_q[1];
    assign o_psum_kn2     = psum_q[2];
    assign o_psum_kn3     = psum_q[3];
    assign o_psum_kn0_val = val_q[0];
    assign o_psum_kn1_val = val_q[1];
    assign o_psum_kn2_val = val_q[2];
    assign o_psum_kn3_val = val_q[3];

endmodule

// File: tb/tb_accelerator_core.sv
// ----------------------------------------------------------------------------
// tb_accelerator_core
//
// Directed bench for accelerator_core. A responder in run_job answers each
// request one cycle later. It also drives decoy strobes in states where they
// must be ignored. Every result is checked against hand-computed values.
// ----------------------------------------------------------------------------
module tb_accelerator_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        o_data_req;
    logic [23:0] i_data;
    logic        i_data_val;
    logic        o_weight_req;
    logic [95:0] i_weight;
    logic        i_weight_val;
    logic [7:0]  o_psum_kn0, o_psum_kn1, o_psum_kn2, o_psum_kn3;
    logic        o_psum_kn0_val, o_psum_kn1_val, o_psum_kn2_val, o_psum_kn3_val;
    logic [31:0] i_conf_ctrl, i_conf_cnt, i_conf_knx;
    logic [31:0] i_conf_weightinterval, i_conf_kernelshape;

    always #5 clk = ~clk;

    accelerator_core dut (
        .clk                   (clk),
        .rst                   (rst),
        .o_data_req            (o_data_req),
        .i_data                (i_data),
        .i_data_val            (i_data_val),
        .o_weight_req          (o_weight_req),
        .i_weight              (i_weight),
        .i_weight_val          (i_weight_val),
        .o_psum_kn0            (o_psum_kn0),
        .o_psum_kn1            (o_psum_kn1),
        .o_psum_kn2            (o_psum_kn2),
        .o_psum_kn3            (o_psum_kn3),
        .o_psum_kn0_val        (o_psum_kn0_val),
        .o_psum_kn1_val        (o_psum_kn1_val),
        .o_psum_kn2_val        (o_psum_kn2_val),
        .o_psum_kn3_val        (o_psum_kn3_val),
        .i_conf_ctrl           (i_conf_ctrl),
        .i_conf_cnt            (i_conf_cnt),
        .i_conf_knx            (i_conf_knx),
        .i_conf_weightinterval (i_conf_weightinterval),
        .i_conf_kernelshape    (i_conf_kernelshape)
    );

    logic [7:0] psum_w [4];
    logic [3:0] val_w;
    assign psum_w[0] = o_psum_kn0;
    assign psum_w[1] = o_psum_kn1;
    assign psum_w[2] = o_psum_kn2;
    assign psum_w[3] = o_psum_kn3;
    assign val_w = {o_psum_kn3_val, o_psum_kn2_val, o_psum_kn1_val, o_psum_kn0_val};

    int n_vec = 0;
    int n_bad = 0;

    logic [95:0] w_sets   [4];
    logic [23:0] d_words  [8];
    int          exp_psum [8][4];
    int          wpos     [4];

    localparam logic [95:0] W_ONES = {12{8'h01}};
    localparam logic [95:0] W_TWOS = {12{8'h02}};
    localparam logic [95:0] W_FFS  = {12{8'hFF}};
    // kernel0 (1,2,3) kernel1 (4,0,0) kernel2 (0,0,10) kernel3 (2,2,2), channel 0 first
    localparam logic [95:0] W_MIX  = 96'h02_02_02_0A_00_00_00_00_04_03_02_01;

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_exp(input int i, input int a, input int b, input int c, input int d);
        exp_psum[i][0] = a;
        exp_psum[i][1] = b;
        exp_psum[i][2] = c;
        exp_psum[i][3] = d;
    endtask

    task automatic check_quiet_outputs(input string tag);
        check_vec({tag, "_wreq"}, 32'(o_weight_req), 32'd0);
        check_vec({tag, "_dreq"}, 32'(o_data_req), 32'd0);
        check_vec({tag, "_vals"}, 32'(val_w), 32'd0);
        check_vec({tag, "_psum"}, {o_psum_kn3, o_psum_kn2, o_psum_kn1, o_psum_kn0}, 32'd0);
    endtask

    // Runs one job. rst_at > 0 aborts the job with a reset while the core
    // waits for data word number rst_at; the caller then takes over.
    task automatic run_job(input string name, input int cnt, input int intv,
                           input logic [3:0] knx, input logic [3:0] nch,
                           input int exp_wreq, input int rst_at);
        int wcnt, dcnt, quiet;
        int rcnt [4];
        bit wsend, dsend, wgo, dgo, timed_out, aborted;
        wcnt = 0; dcnt = 0; quiet = 0;
        wsend = 0; dsend = 0; timed_out = 1; aborted = 0;
        for (int k = 0; k < 4; k++) begin
            rcnt[k] = 0;
            wpos[k] = -1;
        end
        @(negedge clk);
        i_conf_cnt            = cnt;
        i_conf_weightinterval = intv;
        i_conf_knx            = {28'h0, knx};
        i_conf_kernelshape    = {20'h0, nch, 8'h00};
        i_conf_ctrl           = 32'h1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            quiet++;
            if (cyc == 0) begin
                // Config changes mid-job must not take effect
                i_conf_cnt            = 32'd1;
                i_conf_weightinterval = 32'd1;
                i_conf_knx            = 32'd0;
                i_conf_kernelshape    = 32'h100;
            end
            i_weight_val = 1'b0;
            i_data_val   = 1'b0;
            wgo = wsend; dgo = dsend;
            wsend = 0; dsend = 0;
            if (dgo && rst_at > 0 && dcnt == rst_at) begin
                rst        = 1'b0;
                i_data     = 24'h030201;
                i_data_val = 1'b1;
                aborted    = 1;
                break;
            end
            for (int k = 0; k < 4; k++) begin
                if (val_w[k]) begin
                    quiet = 0;
                    if (rcnt[k] < 8)
                        check_vec($sformatf("%s_kn%0d_word%0d", name, k, rcnt[k]),
                                  32'(psum_w[k]), 32'(exp_psum[rcnt[k]][k]));
                    rcnt[k]++;
                end
            end
            if (o_weight_req) begin
                if (wcnt < 4) wpos[wcnt] = dcnt;
                wcnt++;
                wsend = 1; quiet = 0;
                i_data = 24'hFFFFFF;   // decoy: not in DWAIT
                i_data_val = 1'b1;
            end
            if (o_data_req) begin
                dcnt++;
                dsend = 1; quiet = 0;
                i_weight = W_FFS;      // decoy: not in WWAIT
                i_weight_val = 1'b1;
            end
            if (wgo) begin
                i_weight     = (wcnt <= 4) ? w_sets[wcnt-1] : 96'h0;
                i_weight_val = 1'b1;
            end
            if (dgo) begin
                i_data     = (dcnt <= 8) ? d_words[dcnt-1] : 24'h0;
                i_data_val = 1'b1;
            end
            if (quiet >= 10) begin
                timed_out = 0;
                break;
            end
        end
        if (!aborted) begin
            check_vec({name, "_timeout"}, 32'(timed_out), 32'd0);
            check_vec({name, "_wreq_count"}, wcnt, exp_wreq);
            check_vec({name, "_dreq_count"}, dcnt, cnt);
            for (int k = 0; k < 4; k++)
                check_vec($sformatf("%s_kn%0d_val_count", name, k), rcnt[k], knx[k] ? cnt : 0);
            $display("job %s: cnt=%0d weight_req=%0d data_req=%0d results=%0d/%0d/%0d/%0d",
                     name, cnt, wcnt, dcnt, rcnt[0], rcnt[1], rcnt[2], rcnt[3]);
            i_conf_ctrl = 32'h0;
        end
    endtask

    initial begin
        rst = 1'b0;
        i_data = '0; i_data_val = 1'b0;
        i_weight = '0; i_weight_val = 1'b0;
        i_conf_ctrl = '0; i_conf_cnt = '0; i_conf_knx = '0;
        i_conf_weightinterval = '0; i_conf_kernelshape = '0;
        repeat (3) @(negedge clk);
        check_quiet_outputs("reset");
        rst = 1'b1;

        // Basic job: 3+2+1 on every kernel, single weight load
        w_sets[0] = W_ONES;
        for (int i = 0; i < 4; i++) begin
            d_words[i] = 24'h030201;
            set_exp(i, 6, 6, 6, 6);
        end
        run_job("basic", 4, 0, 4'hF, 4'd3, 1, 0);

        // Saturation
        w_sets[0] = W_FFS;
        for (int i = 0; i < 2; i++) begin
            d_words[i] = 24'hFFFFFF;
            set_exp(i, 255, 255, 255, 255);
        end
        run_job("saturate", 2, 0, 4'hF, 4'd3, 1, 0);

        // Weight reload every two words; results follow the new set at once
        w_sets[0] = W_ONES; w_sets[1] = W_MIX; w_sets[2] = W_TWOS;
        d_words[0] = 24'h030201; set_exp(0, 6, 6, 6, 6);
        d_words[1] = 24'h05140A; set_exp(1, 35, 35, 35, 35);
        d_words[2] = 24'h05140A; set_exp(2, 65, 40, 50, 70);
        d_words[3] = 24'h030201; set_exp(3, 14, 4, 30, 12);
        d_words[4] = 24'h030201; set_exp(4, 12, 12, 12, 12);
        d_words[5] = 24'h010101; set_exp(5, 6, 6, 6, 6);
        run_job("interval", 6, 2, 4'hF, 4'd3, 3, 0);
        check_vec("interval_wreq0_pos", wpos[0], 0);
        check_vec("interval_wreq1_pos", wpos[1], 2);
        check_vec("interval_wreq2_pos", wpos[2], 4);

        // Kernel output enable 0x5
        w_sets[0] = W_ONES;
        for (int i = 0; i < 2; i++) begin
            d_words[i] = 24'h030201;
            set_exp(i, 6, 6, 6, 6);
        end
        run_job("knx5", 2, 0, 4'h5, 4'd3, 1, 0);

        // Active channel count, data ch0=4 ch1=9 ch2=9, weights 1
        d_words[0] = 24'h090904;
        set_exp(0, 4, 4, 4, 4);
        run_job("nch1", 1, 0, 4'hF, 4'd1, 1, 0);
        set_exp(0, 13, 13, 13, 13);
        run_job("nch2", 1, 0, 4'hF, 4'd2, 1, 0);
        set_exp(0, 22, 22, 22, 22);
        run_job("nch0", 1, 0, 4'hF, 4'd0, 1, 0);
        run_job("nch5", 1, 0, 4'hF, 4'd5, 1, 0);

        // Zero-length job goes straight to DONE
        run_job("cnt0", 0, 0, 4'hF, 4'd3, 0, 0);

        // Reset while waiting for the second data word
        w_sets[0] = W_ONES;
        for (int i = 0; i < 4; i++) begin
            d_words[i] = 24'h030201;
            set_exp(i, 6, 6, 6, 6);
        end
        run_job("abort", 4, 0, 4'hF, 4'd3, 1, 2);
        @(negedge clk);
        check_quiet_outputs("abort");
        rst = 1'b1;              // stale data strobe still high, ctrl still 1
        @(negedge clk);
        check_vec("abort_restart_wreq", 32'(o_weight_req), 32'd1);
        check_vec("abort_restart_vals", 32'(val_w), 32'd0);
        i_data_val = 1'b0;
        @(negedge clk);
        check_vec("abort_stale_vals", 32'(val_w), 32'd0);
        check_vec("abort_stale_psum", {o_psum_kn3, o_psum_kn2, o_psum_kn1, o_psum_kn0}, 32'd0);
        check_vec("abort_wwait_dreq", 32'(o_data_req), 32'd0);
        $display("job abort: reset in DWAIT, restart with fresh weight request");

        i_conf_ctrl = 32'h0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_quiet_outputs("final_reset");
        rst = 1'b1;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d vectors applied", n_vec);
        $fatal(1, "watchdog expired");
    end

endmodule
